mem_responder: RTL and testbench

- Memory-side responder for the processor's memory handshake.
- Accepts read/write requests from the control/datapath side (MA address, MD write data).
- Holds a word-addressed on-chip RAM and inserts a programmable number of wait states.
- Returns read data with a one-cycle ready pulse that drives the processor's ready input, which gates each control step.

---
 rtl/mem_responder.sv | 120 ++++++++++++
 tb/tb_mem_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: word-addressed RAM behind a level read/write handshake,
// with a programmable number of wait states and a one-cycle completion pulse.
//
// state   | meaning
// ST_IDLE | waiting for iRead/iWrite; a request seen on an edge is accepted
// ST_WAIT | counting down wait states; the RAM access happens when count is 0
// ST_RESP | oRdy (with oErr) high for exactly one cycle, then back to idle
module mem_responder #(
   parameter int ADDR_W = 9,
   parameter int WAIT   = 2
) (
   input  logic        iClk,
   input  logic        nRst,
   input  logic        iRead,
   input  logic        iWrite,
   input  logic [31:0] iAddr,
   input  logic [31:0] iData,
   output logic [31:0] oData,
   output logic        oRdy,
   output logic        oBusy,
   output logic        oErr
);
   localparam int         DEPTH    = 2 ** ADDR_W;
   localparam logic [3:0] WAIT_CNT = 4'(WAIT);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              in_range;
   logic              illegal;
   logic              mem_we;
   logic [ADDR_W-1:0] word_addr;
   logic [31:0]       mem [DEPTH];

   assign word_addr = addr_q[ADDR_W-1:0];
   assign in_range  = (addr_q >> ADDR_W) == 32'd0;
   assign illegal   = rd_q & wr_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      rdata_d = rdata_q;
      err_d   = 1'b0;
      mem_we  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (iRead || iWrite) begin
               addr_d  = iAddr;
               wdata_d = iData;
               rd_d    = iRead;
               wr_d    = iWrite;
               cnt_d   = WAIT_CNT;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               // err_q is only ever set here, so it is naturally zero outside RESP
               err_d   = illegal | ~in_range;
               state_d = ST_RESP;
               if (!illegal) begin
                  if (rd_q) begin
                     rdata_d = in_range ? mem[word_addr] : 32'd0;
                  end else begin
                     mem_we = in_range;
                  end
               end
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge iClk or negedge nRst) begin
      if (!nRst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // RAM contents survive reset; mem_we is already gated by the reset state
   always_ff @(posedge iClk) begin
      if (mem_we) mem[word_addr] <= wdata_q;
   end

   assign oData = rdata_q;
   assign oRdy  = (state_q == ST_RESP);
   assign oBusy = (state_q != ST_IDLE);
   assign oErr  = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus randomized traffic checked
// against an array-based model of the RAM and the read-data register.
module tb_mem_responder;
   localparam int ADDR_W = 9;
   localparam int WAIT_N = 2;
   localparam int DEPTH  = 2 ** ADDR_W;

   logic        iClk   = 1'b0;
   logic        nRst   = 1'b0;
   logic        iRead  = 1'b0;
   logic        iWrite = 1'b0;
   logic [31:0] iAddr  = 32'd0;
   logic [31:0] iData  = 32'd0;
   logic [31:0] oData;
   logic        oRdy;
   logic        oBusy;
   logic        oErr;

   mem_responder #(.ADDR_W(ADDR_W), .WAIT(WAIT_N)) dut (
      .iClk  (iClk),
      .nRst  (nRst),
      .iRead (iRead),
      .iWrite(iWrite),
      .iAddr (iAddr),
      .iData (iData),
      .oData (oData),
      .oRdy  (oRdy),
      .oBusy (oBusy),
      .oErr  (oErr)
   );

   always #5 iClk = ~iClk;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_odata;
   logic        exp_err;
   int          lat;
   logic [31:0] rdata, dafter;
   logic        err, busy_ok, rdy_after, err_after;

   // Reference: what one access does to RAM, to the read-data register, and to oErr.
   task automatic model(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data);
      if (rd && wr) begin
         exp_err = 1'b1;
      end else if (addr >= 32'(DEPTH)) begin
         exp_err = 1'b1;
         if (rd) m_odata = 32'd0;
      end else begin
         exp_err = 1'b0;
         if (rd) m_odata = m_mem[addr[ADDR_W-1:0]];
         else    m_mem[addr[ADDR_W-1:0]] = data;
      end
   endtask

   // Drives one request, drops it right after acceptance (scrambling iAddr/iData
   // to stray values), and reports what the DUT showed.
   task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] stray);
      @(negedge iClk);
      iRead = rd; iWrite = wr; iAddr = addr; iData = data;
      @(posedge iClk); #1;
      iRead = 1'b0; iWrite = 1'b0; iAddr = stray; iData = $urandom();
      busy_ok = oBusy;
      lat = 0;
      while (oRdy !== 1'b1 && lat < 40) begin
         @(posedge iClk); #1;
         lat++;
         if (oBusy !== 1'b1) busy_ok = 1'b0;
      end
      rdata = oData;
      err   = oErr;
      @(posedge iClk); #1;
      rdy_after = oRdy;
      err_after = oErr;
      dafter    = oData;
   endtask

   task automatic test_reset();
      nRst = 1'b0;
      repeat (2) @(posedge iClk);
      #1;
      n_chk++; if (oData !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", oData); end
      n_chk++; if (oRdy !== 1'b0)   begin n_fail++; $display("FAIL reset_rdy: got %b expected 0", oRdy); end
      n_chk++; if (oBusy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b expected 0", oBusy); end
      n_chk++; if (oErr !== 1'b0)   begin n_fail++; $display("FAIL reset_err: got %b expected 0", oErr); end
      m_odata = 32'd0;
      @(negedge iClk);
      nRst = 1'b1;
   endtask

   task automatic test_write_read();
      model(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h30);
      n_chk++; if (lat != WAIT_N + 1) begin n_fail++; $display("FAIL wr_latency: got %0d edges expected %0d", lat, WAIT_N + 1); end
      n_chk++; if (busy_ok !== 1'b1) begin n_fail++; $display("FAIL wr_busy: got %b expected 1", busy_ok); end
      n_chk++; if (err !== exp_err) begin n_fail++; $display("FAIL wr_err: got %b expected %b", err, exp_err); end
      n_chk++; if (rdy_after !== 1'b0) begin n_fail++; $display("FAIL wr_rdy_pulse: got %b expected 0", rdy_after); end
      n_chk++; if (rdata !== m_odata) begin n_fail++; $display("FAIL wr_data_unchanged: got %h expected %h", rdata, m_odata); end
      model(1'b1, 1'b0, 32'h10, 32'd0);
      do_access(1'b1, 1'b0, 32'h10, 32'd0, 32'h30);
      n_chk++; if (rdata !== m_odata) begin n_fail++; $display("FAIL rd_data: got %h expected %h", rdata, m_odata); end
      n_chk++; if (err !== exp_err) begin n_fail++; $display("FAIL rd_err: got %b expected %b", err, exp_err); end
      n_chk++; if (dafter !== m_odata) begin n_fail++; $display("FAIL rd_hold: got %h expected %h", dafter, m_odata); end
      n_chk++; if (err_after !== 1'b0) begin n_fail++; $display("FAIL rd_err_clear: got %b expected 0", err_after); end
   endtask

   task automatic test_out_of_range();
      model(1'b0, 1'b1, 32'h0, 32'h0BADF00D);
      do_access(1'b0, 1'b1, 32'h0, 32'h0BADF00D, 32'h0);
      model(1'b0, 1'b1, 32'h200, 32'h1);
      do_access(1'b0, 1'b1, 32'h200, 32'h1, 32'h0);
      n_chk++; if (err !== exp_err) begin n_fail++; $display("FAIL oor_wr_err: got %b expected %b", err, exp_err); end
      n_chk++; if (err_after !== 1'b0) begin n_fail++; $display("FAIL oor_err_pulse: got %b expected 0", err_after); end
      model(1'b1, 1'b0, 32'h0, 32'd0);
      do_access(1'b1, 1'b0, 32'h0, 32'd0, 32'h200);
      n_chk++; if (rdata !== m_odata) begin n_fail++; $display("FAIL oor_no_alias: got %h expected %h", rdata, m_odata); end
      model(1'b1, 1'b0, 32'h8000_0010, 32'd0);
      do_access(1'b1, 1'b0, 32'h8000_0010, 32'd0, 32'h0);
      n_chk++; if (rdata !== m_odata) begin n_fail++; $display("FAIL oor_rd_data: got %h expected %h", rdata, m_odata); end
      n_chk++; if (err !== exp_err) begin n_fail++; $display("FAIL oor_rd_err: got %b expected %b", err, exp_err); end
   endtask

   task automatic test_illegal();
      model(1'b1, 1'b1, 32'h10, 32'h5555AAAA);
      do_access(1'b1, 1'b1, 32'h10, 32'h5555AAAA, 32'h10);
      n_chk++; if (err !== exp_err) begin n_fail++; $display("FAIL both_err: got %b expected %b", err, exp_err); end
      n_chk++; if (rdata !== m_odata) begin n_fail++; $display("FAIL both_data_unchanged: got %h expected %h", rdata, m_odata); end
      model(1'b1, 1'b0, 32'h10, 32'd0);
      do_access(1'b1, 1'b0, 32'h10, 32'd0, 32'h0);
      n_chk++; if (rdata !== m_odata) begin n_fail++; $display("FAIL both_no_write: got %h expected %h", rdata, m_odata); end
   endtask

   task automatic test_reset_mid_write();
      model(1'b0, 1'b1, 32'h20, 32'hAAAAAAAA);
      do_access(1'b0, 1'b1, 32'h20, 32'hAAAAAAAA, 32'h0);
      @(negedge iClk);
      iWrite = 1'b1; iAddr = 32'h20; iData = 32'h12345678;
      @(posedge iClk); #1;
      iWrite = 1'b0;
      @(posedge iClk); #1;
      nRst = 1'b0;
      #1;
      m_odata = 32'd0;
      n_chk++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", oBusy); end
      n_chk++; if (oRdy !== 1'b0)  begin n_fail++; $display("FAIL rst_mid_rdy: got %b expected 0", oRdy); end
      n_chk++; if (oData !== m_odata) begin n_fail++; $display("FAIL rst_mid_data: got %h expected %h", oData, m_odata); end
      repeat (2) @(negedge iClk);
      nRst = 1'b1;
      model(1'b1, 1'b0, 32'h20, 32'd0);
      do_access(1'b1, 1'b0, 32'h20, 32'd0, 32'h0);
      n_chk++; if (rdata !== m_odata) begin n_fail++; $display("FAIL rst_mid_no_commit: got %h expected %h", rdata, m_odata); end
   endtask

   task automatic test_addr_change();
      model(1'b0, 1'b1, 32'h30, 32'h30303030);
      do_access(1'b0, 1'b1, 32'h30, 32'h30303030, 32'h10);
      model(1'b1, 1'b0, 32'h10, 32'd0);
      do_access(1'b1, 1'b0, 32'h10, 32'd0, 32'h30);
      n_chk++; if (rdata !== m_odata) begin n_fail++; $display("FAIL addr_change: got %h expected %h", rdata, m_odata); end
   endtask

   task automatic test_back_to_back();
      int e, first, second;
      logic prev;
      logic [31:0] d1, d2;
      first = -1; second = -1; prev = 1'b0; e = 0;
      d1 = 32'd0; d2 = 32'd0;
      model(1'b1, 1'b0, 32'h10, 32'd0);
      @(negedge iClk);
      iRead = 1'b1; iAddr = 32'h10;
      @(posedge iClk); #1;
      while (second < 0 && e < 40) begin
         @(posedge iClk); #1;
         e++;
         if (oRdy === 1'b1 && !prev) begin
            if (first < 0) begin first = e; d1 = oData; end
            else begin second = e; d2 = oData; end
         end
         prev = oRdy;
      end
      iRead = 1'b0;
      n_chk++; if (first != WAIT_N + 1) begin n_fail++; $display("FAIL b2b_first: got edge %0d expected %0d", first, WAIT_N + 1); end
      n_chk++; if (second - first != WAIT_N + 3) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected %0d", second - first, WAIT_N + 3); end
      n_chk++; if (d1 !== m_odata || d2 !== m_odata) begin n_fail++; $display("FAIL b2b_data: got %h/%h expected %h", d1, d2, m_odata); end
      repeat (2) @(posedge iClk);
      #1;
      n_chk++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL b2b_no_third: got busy %b expected 0", oBusy); end
   endtask

   task automatic test_random();
      logic        rd, wr;
      logic [31:0] addr, data;
      int          kind;
      for (int a = 0; a < 16; a++) begin
         data = $urandom();
         model(1'b0, 1'b1, 32'(a), data);
         do_access(1'b0, 1'b1, 32'(a), data, $urandom());
      end
      for (int i = 0; i < 60; i++) begin
         kind = $urandom_range(0, 9);
         data = $urandom();
         addr = 32'($urandom_range(0, 15));
         rd = 1'b0; wr = 1'b0;
         if (kind <= 3)      rd = 1'b1;
         else if (kind <= 6) wr = 1'b1;
         else if (kind == 7) begin wr = 1'b1; addr = $urandom() | 32'h200; end
         else if (kind == 8) begin rd = 1'b1; addr = $urandom() | 32'h200; end
         else begin rd = 1'b1; wr = 1'b1; end
         model(rd, wr, addr, data);
         do_access(rd, wr, addr, data, $urandom());
         n_chk++; if (lat != WAIT_N + 1) begin n_fail++; $display("FAIL rand_latency op %0d: got %0d expected %0d", i, lat, WAIT_N + 1); end
         n_chk++; if (err !== exp_err) begin n_fail++; $display("FAIL rand_err op %0d: got %b expected %b", i, err, exp_err); end
         n_chk++; if (rdata !== m_odata) begin n_fail++; $display("FAIL rand_data op %0d: got %h expected %h", i, rdata, m_odata); end
         n_chk++; if (rdy_after !== 1'b0 || err_after !== 1'b0) begin n_fail++; $display("FAIL rand_pulse op %0d: got rdy %b err %b expected 0 0", i, rdy_after, err_after); end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_out_of_range();
      test_illegal();
      test_reset_mid_write();
      test_addr_change();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
